// File: rtl/team_06_lcd_pkg.sv
// rtl/team_06_lcd_pkg.sv - LCD command constants and controller state types
package team_06_lcd_pkg;

    localparam logic [7:0] CMD_FUNC_SET = 8'h38;
    localparam logic [7:0] CMD_DISP_ON  = 8'h0C;
    localparam logic [7:0] CMD_CLEAR    = 8'h01;
    localparam logic [7:0] CMD_ENTRY    = 8'h06;
    localparam logic [7:0] CMD_LINE1    = 8'h80;
    localparam logic [7:0] CMD_LINE2    = 8'hC0;

    typedef enum logic [2:0] {
        ST_POWER_WAIT,
        ST_INIT,
        ST_IDLE,
        ST_ADDR1,
        ST_ROW1,
        ST_ADDR2,
        ST_ROW2,
        ST_DONE
    } lcd_state_t;

    typedef enum logic [1:0] {
        BW_IDLE,
        BW_SETUP,
        BW_PULSE,
        BW_HOLD
    } bw_state_t;

    function automatic logic [7:0] init_cmd(input logic [1:0] idx);
        case (idx)
            2'd0:    return CMD_FUNC_SET;
            2'd1:    return CMD_DISP_ON;
            2'd2:    return CMD_CLEAR;
            default: return CMD_ENTRY;
        endcase
    endfunction

endpackage

// File: rtl/team_06_lcd_byte_writer.sv
// rtl/team_06_lcd_byte_writer.sv - one LCD byte: setup, enable pulse, post-byte wait
module team_06_lcd_byte_writer
    import team_06_lcd_pkg::*;
#(
    parameter int unsigned E_PULSE_CYCLES    = 5,
    parameter int unsigned CMD_WAIT_CYCLES   = 500,
    parameter int unsigned CLEAR_WAIT_CYCLES = 20000,
    parameter int unsigned CNT_W             = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       rs,
    input  logic [7:0] data,
    input  logic       long_wait,
    output logic       lcd_en,
    output logic       lcd_rs,
    output logic [7:0] lcd_data,
    output logic       done,
    output logic       busy
);

    bw_state_t        state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n, hold_last;
    logic             long_q;
    logic             accept;

    // A new byte may be accepted on the last HOLD cycle so transfers run back to back.
    always_comb begin
        hold_last = long_q ? CNT_W'(CLEAR_WAIT_CYCLES - 1) : CNT_W'(CMD_WAIT_CYCLES - 1);
        done      = (state == BW_HOLD) && (cnt == hold_last);
        accept    = start && ((state == BW_IDLE) || done);
        state_n   = state;
        cnt_n     = cnt + CNT_W'(1);
        case (state)
            BW_SETUP: begin
                state_n = BW_PULSE;
                cnt_n   = '0;
            end
            BW_PULSE: begin
                if (cnt == CNT_W'(E_PULSE_CYCLES - 1)) begin
                    state_n = BW_HOLD;
                    cnt_n   = '0;
                end
            end
            BW_HOLD: begin
                if (done) begin
                    state_n = BW_IDLE;
                    cnt_n   = '0;
                end
            end
            default: cnt_n = '0;
        endcase
        if (accept) begin
            state_n = BW_SETUP;
            cnt_n   = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= BW_IDLE;
            cnt      <= '0;
            lcd_rs   <= 1'b0;
            lcd_data <= 8'h00;
            long_q   <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            if (accept) begin
                lcd_rs   <= rs;
                lcd_data <= data;
                long_q   <= long_wait;
            end
        end
    end

    assign lcd_en = (state == BW_PULSE);
    assign busy   = (state != BW_IDLE);

endmodule

// File: rtl/team_06_lcd_controller.sv
// rtl/team_06_lcd_controller.sv - HD44780 16x2 init and row refresh sequencer
module team_06_lcd_controller
    import team_06_lcd_pkg::*;
#(
    parameter int unsigned POWER_ON_CYCLES   = 400000,
    parameter int unsigned E_PULSE_CYCLES    = 5,
    parameter int unsigned CMD_WAIT_CYCLES   = 500,
    parameter int unsigned CLEAR_WAIT_CYCLES = 20000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [127:0] row_1,
    input  logic [127:0] row_2,
    input  logic         force_refresh,
    output logic         lcd_en,
    output logic         lcd_rs,
    output logic         lcd_rw,
    output logic [7:0]   lcd_data,
    output logic         init_done,
    output logic         busy,
    output logic         frame_done
);

    localparam int unsigned MAX_A    = (CMD_WAIT_CYCLES > CLEAR_WAIT_CYCLES) ? CMD_WAIT_CYCLES : CLEAR_WAIT_CYCLES;
    localparam int unsigned MAX_B    = (E_PULSE_CYCLES > MAX_A) ? E_PULSE_CYCLES : MAX_A;
    localparam int unsigned MAX_WAIT = (POWER_ON_CYCLES > MAX_B) ? POWER_ON_CYCLES : MAX_B;
    localparam int unsigned CNT_W    = $clog2(MAX_WAIT) + 1;

    lcd_state_t       state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [1:0]       idx, idx_n;
    logic [3:0]       col, col_n;
    logic [127:0]     snap_1, snap_2;
    logic             refresh_pending;
    logic             frame_req, capture, bw_start, bw_rs, bw_long, bw_done, bw_busy;
    logic [7:0]       bw_data;

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        idx_n     = idx;
        col_n     = col;
        bw_start  = 1'b0;
        capture   = 1'b0;
        frame_req = ({row_1, row_2} != {snap_1, snap_2}) || refresh_pending || force_refresh;
        case (state)
            ST_POWER_WAIT: begin
                if (cnt == CNT_W'(POWER_ON_CYCLES - 1)) begin
                    state_n  = ST_INIT;
                    cnt_n    = '0;
                    idx_n    = 2'd0;
                    bw_start = 1'b1;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            ST_INIT: begin
                if (bw_done) begin
                    if (idx == 2'd3) begin
                        state_n = ST_IDLE;
                    end else begin
                        idx_n    = idx + 2'd1;
                        bw_start = 1'b1;
                    end
                end
            end
            ST_IDLE: begin
                if (frame_req && !bw_busy) begin
                    state_n  = ST_ADDR1;
                    capture  = 1'b1;
                    bw_start = 1'b1;
                end
            end
            ST_ADDR1, ST_ADDR2: begin
                if (bw_done) begin
                    state_n  = (state == ST_ADDR1) ? ST_ROW1 : ST_ROW2;
                    col_n    = 4'd0;
                    bw_start = 1'b1;
                end
            end
            ST_ROW1, ST_ROW2: begin
                // col wraps 15 -> 0 on the row change.
                if (bw_done) begin
                    col_n = col + 4'd1;
                    if (col != 4'd15) begin
                        bw_start = 1'b1;
                    end else if (state == ST_ROW1) begin
                        state_n  = ST_ADDR2;
                        bw_start = 1'b1;
                    end else begin
                        state_n = ST_DONE;
                    end
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // Byte content follows the state being entered, so start and data line up on one edge.
    always_comb begin
        bw_rs   = 1'b0;
        bw_data = 8'h00;
        bw_long = (state_n == ST_INIT) && (idx_n == 2'd2);
        case (state_n)
            ST_INIT:  bw_data = init_cmd(idx_n);
            ST_ADDR1: bw_data = CMD_LINE1;
            ST_ADDR2: bw_data = CMD_LINE2;
            ST_ROW1: begin
                bw_rs   = 1'b1;
                bw_data = 8'(snap_1 >> {~col_n, 3'b000});
            end
            ST_ROW2: begin
                bw_rs   = 1'b1;
                bw_data = 8'(snap_2 >> {~col_n, 3'b000});
            end
            default: bw_data = 8'h00;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state           <= ST_POWER_WAIT;
            cnt             <= '0;
            idx             <= 2'd0;
            col             <= 4'd0;
            snap_1          <= '0;
            snap_2          <= '0;
            refresh_pending <= 1'b1;
            init_done       <= 1'b0;
            busy            <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            idx   <= idx_n;
            col   <= col_n;
            busy  <= (state_n != ST_IDLE);
            if (capture) begin
                snap_1          <= row_1;
                snap_2          <= row_2;
                refresh_pending <= 1'b0;
            end else if (force_refresh && (state != ST_POWER_WAIT) && (state != ST_INIT)
                         && (state != ST_IDLE)) begin
                refresh_pending <= 1'b1;
            end
            if ((state == ST_INIT) && (state_n == ST_IDLE)) begin
                init_done <= 1'b1;
            end
        end
    end

    assign frame_done = (state == ST_DONE);
    assign lcd_rw     = 1'b0;

    team_06_lcd_byte_writer #(
        .E_PULSE_CYCLES   (E_PULSE_CYCLES),
        .CMD_WAIT_CYCLES  (CMD_WAIT_CYCLES),
        .CLEAR_WAIT_CYCLES(CLEAR_WAIT_CYCLES),
        .CNT_W            (CNT_W)
    ) u_byte_writer (
        .clk      (clk),
        .rst      (rst),
        .start    (bw_start),
        .rs       (bw_rs),
        .data     (bw_data),
        .long_wait(bw_long),
        .lcd_en   (lcd_en),
        .lcd_rs   (lcd_rs),
        .lcd_data (lcd_data),
        .done     (bw_done),
        .busy     (bw_busy)
    );

endmodule

// File: tb/tb_team_06_lcd_controller.sv
// tb/tb_team_06_lcd_controller.sv - scoreboard bench for team_06_lcd_controller
module tb_team_06_lcd_controller;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [127:0] row_1 = '0;
    logic [127:0] row_2 = '0;
    logic         force_refresh = 1'b0;
    logic         lcd_en, lcd_rs, lcd_rw, init_done, busy, frame_done;
    logic [7:0]   lcd_data;

    team_06_lcd_controller #(
        .POWER_ON_CYCLES  (20),
        .E_PULSE_CYCLES   (2),
        .CMD_WAIT_CYCLES  (4),
        .CLEAR_WAIT_CYCLES(10)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .row_1        (row_1),
        .row_2        (row_2),
        .force_refresh(force_refresh),
        .lcd_en       (lcd_en),
        .lcd_rs       (lcd_rs),
        .lcd_rw       (lcd_rw),
        .lcd_data     (lcd_data),
        .init_done    (init_done),
        .busy         (busy),
        .frame_done   (frame_done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int en_rises = 0;
    int frames   = 0;
    int addr_rise_cyc = 0;

    // entry = {first byte of a burst, rs, data}
    logic [9:0] exp_q[$];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic push_init();
        exp_q.push_back({1'b1, 1'b0, 8'h38});
        exp_q.push_back({1'b0, 1'b0, 8'h0C});
        exp_q.push_back({1'b0, 1'b0, 8'h01});
        exp_q.push_back({1'b0, 1'b0, 8'h06});
    endtask

    task automatic push_frame(input logic [127:0] r1, input logic [127:0] r2);
        exp_q.push_back({1'b1, 1'b0, 8'h80});
        for (int c = 0; c < 16; c++) exp_q.push_back({1'b0, 1'b1, r1[127-8*c -: 8]});
        exp_q.push_back({1'b0, 1'b0, 8'hC0});
        for (int c = 0; c < 16; c++) exp_q.push_back({1'b0, 1'b1, r2[127-8*c -: 8]});
    endtask

    // Monitor: every enable pulse pops one expected byte and checks pulse/gap widths.
    logic       prev_en = 1'b0;
    int         hi_cnt = 0;
    int         low_cnt = 0;
    logic [9:0] last_e = '0;
    always @(negedge clk) begin
        logic [9:0] e;
        cyc++;
        if (!rst) begin
            prev_en = 1'b0;
            hi_cnt  = 0;
            low_cnt = 0;
        end else begin
            if (lcd_en) begin
                if (!prev_en) begin
                    en_rises++;
                    check_eq("byte_expected", 32'(exp_q.size() > 0), 1);
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        check_eq("byte_data", 32'(lcd_data), 32'(e[7:0]));
                        check_eq("byte_rs", 32'(lcd_rs), 32'(e[8]));
                        if (!e[9])
                            check_eq("gap_len", low_cnt,
                                     (last_e[8] == 1'b0 && last_e[7:0] == 8'h01) ? 11 : 5);
                        if (e[9] && e[7:0] == 8'h80) addr_rise_cyc = cyc;
                        last_e = e;
                    end
                    low_cnt = 0;
                end
                hi_cnt++;
            end else begin
                if (prev_en) begin
                    check_eq("pulse_len", hi_cnt, 2);
                    hi_cnt = 0;
                end
                low_cnt++;
            end
            if (frame_done) begin
                frames++;
                check_eq("frame_len", cyc - addr_rise_cyc, 237);
            end
            if (lcd_rw !== 1'b0) check_eq("lcd_rw", 32'(lcd_rw), 0);
            prev_en = lcd_en;
        end
    end

    task automatic wait_rises(input int target, input int budget);
        int i;
        for (i = 0; i < budget && en_rises < target; i++) @(negedge clk);
        if (en_rises < target) check_eq("wait_rises_timeout", en_rises, target);
    endtask

    task automatic wait_idle(input int budget);
        int quiet;
        int i;
        quiet = 0;
        for (i = 0; i < budget && quiet < 3; i++) begin
            @(negedge clk);
            if (!busy && exp_q.size() == 0) quiet++;
            else quiet = 0;
        end
        if (quiet < 3) check_eq("wait_idle_timeout", 32'(exp_q.size()), 0);
    endtask

    task automatic pulse_force();
        @(negedge clk);
        force_refresh = 1'b1;
        @(negedge clk);
        force_refresh = 1'b0;
    endtask

    task automatic check_power_wait();
        int hits;
        hits = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (lcd_en) hits++;
        end
        check_eq("power_wait_quiet", hits, 0);
        check_eq("power_wait_busy", 32'(busy), 1);
        check_eq("power_wait_init_done", 32'(init_done), 0);
    endtask

    logic [127:0] listen_row, echo_row, ff_row, alt_row;
    int base, f0;

    initial begin
        listen_row = {"LISTEN", {10{8'h20}}};
        echo_row   = {"ECHO", {12{8'h20}}};
        ff_row     = {16{8'hFF}};
        alt_row    = {"0123456789ABCDEF"};
        row_1 = listen_row;
        row_2 = ff_row;

        // Reset state
        repeat (3) @(negedge clk);
        check_eq("rst_en", 32'(lcd_en), 0);
        check_eq("rst_rs", 32'(lcd_rs), 0);
        check_eq("rst_data", 32'(lcd_data), 0);
        check_eq("rst_outs", {init_done, busy, frame_done}, 0);

        // Power-on, init sequence and first frame from refresh_pending
        push_init();
        push_frame(listen_row, ff_row);
        rst = 1'b1;
        check_power_wait();
        wait_idle(2000);
        check_eq("init_done", 32'(init_done), 1);
        check_eq("first_frames", frames, 1);

        // Unchanged rows stay quiet, then one forced frame
        base = en_rises;
        repeat (1000) @(negedge clk);
        check_eq("idle_quiet", en_rises - base, 0);
        f0 = frames;
        push_frame(listen_row, ff_row);
        pulse_force();
        wait_idle(2000);
        check_eq("force_one_frame", frames - f0, 1);

        // Row change mid-frame: current frame keeps snapshot, next frame carries the change
        f0 = frames;
        base = en_rises;
        push_frame(listen_row, ff_row);
        pulse_force();
        wait_rises(base + 5, 500);
        row_1 = echo_row;
        push_frame(echo_row, ff_row);
        wait_idle(3000);
        check_eq("change_frames", frames - f0, 2);

        // Two forces in one frame give exactly one extra frame
        f0 = frames;
        base = en_rises;
        push_frame(echo_row, ff_row);
        pulse_force();
        wait_rises(base + 3, 500);
        pulse_force();
        wait_rises(base + 10, 500);
        pulse_force();
        push_frame(echo_row, ff_row);
        wait_idle(3000);
        repeat (300) @(negedge clk);
        check_eq("double_force_frames", frames - f0, 2);
        check_eq("double_force_quiet", 32'(exp_q.size()), 0);

        // Reset while lcd_en is high inside ROW2
        base = en_rises;
        row_2 = alt_row;
        push_frame(echo_row, alt_row);
        wait_rises(base + 20, 1000);
        check_eq("mid_row2_en", 32'(lcd_en), 1);
        #1;
        rst = 1'b0;
        #1;
        check_eq("async_rst_en", 32'(lcd_en), 0);
        check_eq("async_rst_data", 32'(lcd_data), 0);
        check_eq("async_rst_outs", {init_done, busy, lcd_rs}, 0);
        exp_q.delete();
        repeat (3) @(negedge clk);
        f0 = frames;
        push_init();
        push_frame(echo_row, alt_row);
        rst = 1'b1;
        check_power_wait();
        wait_idle(2000);
        check_eq("reinit_done", 32'(init_done), 1);
        check_eq("reinit_frames", frames - f0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
